// File: rtl/execute_cycle_pkg.sv
// rtl/execute_cycle_pkg.sv - shared encodings for the execute stage and its RV32M unit
package execute_cycle_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

endpackage

// File: rtl/execute_cycle_muldiv_unit.sv
// rtl/execute_cycle_muldiv_unit.sv - iterative radix-2 RV32M unit (built only with EXEC_MULDIV_EN)
`ifdef EXEC_MULDIV_EN
module muldiv_unit
  import execute_cycle_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  md_state_t   state, state_next;
  logic [4:0]  count;
  logic [2:0]  op_q;
  logic [31:0] hi, lo, m;
  logic        neg_q, b_zero_q;

  logic        a_signed, b_signed, a_neg, b_neg, res_neg;
  logic [31:0] a_mag, b_mag;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op)
      MD_MULH, MD_DIV, MD_REM: begin a_signed = 1'b1; b_signed = 1'b1; end
      MD_MULHSU:               a_signed = 1'b1;
      MD_MUL, MD_MULHU, MD_DIVU, MD_REMU: ;
      default: ;
    endcase
    a_neg   = a_signed & a[31];
    b_neg   = b_signed & b[31];
    res_neg = (op == MD_REM) ? a_neg : (a_neg ^ b_neg);
    a_mag   = a_neg ? -a : a;
    b_mag   = b_neg ? -b : b;
  end

  // lo holds the multiplier (shifts right) or the dividend/quotient (shifts left)
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_rem;
  assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, m} : 33'd0);
  assign div_shift = {hi, lo[31]};
  assign div_ge    = div_shift >= {1'b0, m};
  assign div_rem   = div_shift[31:0] - m;

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      MD_IDLE: if (start) begin busy = 1'b1; state_next = MD_BUSY; end
      MD_BUSY: begin busy = 1'b1; if (count == 5'd31) state_next = MD_DONE; end
      MD_DONE: begin done = 1'b1; state_next = MD_IDLE; end
      default: state_next = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= MD_IDLE;
      count    <= 5'd0;
      op_q     <= 3'd0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      m        <= 32'd0;
      neg_q    <= 1'b0;
      b_zero_q <= 1'b0;
    end else begin
      state <= state_next;
      if (state == MD_IDLE && start) begin
        op_q     <= op;
        hi       <= 32'd0;
        lo       <= a_mag;
        m        <= b_mag;
        neg_q    <= res_neg;
        b_zero_q <= (b == 32'd0);
        count    <= 5'd0;
      end else if (state == MD_BUSY) begin
        count <= count + 5'd1;
        if (!op_q[2]) begin
          hi <= mul_sum[32:1];
          lo <= {mul_sum[0], lo[31:1]};
        end else if (div_ge) begin
          hi <= div_rem;
          lo <= {lo[30:0], 1'b1};
        end else begin
          hi <= div_shift[31:0];
          lo <= {lo[30:0], 1'b0};
        end
      end
    end
  end

  logic [63:0] prod;
  logic [31:0] quo, rem;
  always_comb begin
    prod = neg_q ? -{hi, lo} : {hi, lo};
    // a zero divisor keeps an all-ones quotient regardless of dividend sign
    quo  = b_zero_q ? 32'hFFFF_FFFF : (neg_q ? -lo : lo);
    rem  = neg_q ? -hi : hi;
    case (op_q)
      MD_MUL:                      result = prod[31:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result = prod[63:32];
      MD_DIV, MD_DIVU:             result = quo;
      default:                     result = rem;
    endcase
  end

endmodule
`endif

// File: rtl/execute_cycle.sv
// rtl/execute_cycle.sv - EX stage: forwarding, ALU, BEQ resolve, EX/MEM register
// Optional RV32M unit compiled in with EXEC_MULDIV_EN.
module execute_cycle
  import execute_cycle_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteE,
  input  logic        MemWriteE,
  input  logic        ResultSrcE,
  input  logic        BranchE,
  input  logic        ALUSrcE,
  input  logic [2:0]  ALUControlE,
  input  logic        MulDivE,
  input  logic [2:0]  MulDivOpE,
  input  logic [31:0] RD1_E,
  input  logic [31:0] RD2_E,
  input  logic [31:0] Imm_Ext_E,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  RD_E,
  input  logic [1:0]  ForwardA_E,
  input  logic [1:0]  ForwardB_E,
  input  logic [31:0] ResultW,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        StallE,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic        ResultSrcM,
  output logic [4:0]  RD_M,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic [31:0] PCPlus4M
);

  logic [31:0] src_a, src_b_fwd, src_b, alu_result, ex_result;
  logic        stall;

  always_comb begin
    case (ForwardA_E)
      FWD_REG: src_a = RD1_E;
      FWD_WB:  src_a = ResultW;
      FWD_MEM: src_a = ALUResultM;
      default: src_a = RD1_E;
    endcase
    case (ForwardB_E)
      FWD_REG: src_b_fwd = RD2_E;
      FWD_WB:  src_b_fwd = ResultW;
      FWD_MEM: src_b_fwd = ALUResultM;
      default: src_b_fwd = RD2_E;
    endcase
    src_b = ALUSrcE ? Imm_Ext_E : src_b_fwd;
  end

  always_comb begin
    case (ALUControlE)
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_SLT: alu_result = {31'd0, $signed(src_a) < $signed(src_b)};
      default: alu_result = 32'd0;
    endcase
  end

  assign PCSrcE    = BranchE & (alu_result == 32'd0);
  assign PCTargetE = PCE + Imm_Ext_E;

`ifdef EXEC_MULDIV_EN
  logic        md_done;
  logic [31:0] md_result;

  muldiv_unit u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (MulDivE),
    .op     (MulDivOpE),
    .a      (src_a),
    .b      (src_b_fwd),
    .busy   (stall),
    .done   (md_done),
    .result (md_result)
  );

  assign ex_result = (MulDivE && md_done) ? md_result : alu_result;
`else
  logic unused_muldiv;
  assign unused_muldiv = ^{MulDivE, MulDivOpE};
  assign stall         = 1'b0;
  assign ex_result     = alu_result;
`endif

  assign StallE = stall;

  // a stalled edge loads a bubble; data fields are don't-care then
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 1'b0;
      RD_M       <= 5'd0;
      ALUResultM <= 32'd0;
      WriteDataM <= 32'd0;
      PCPlus4M   <= 32'd0;
    end else begin
      RegWriteM  <= RegWriteE & ~stall;
      MemWriteM  <= MemWriteE & ~stall;
      RD_M       <= stall ? 5'd0 : RD_E;
      ResultSrcM <= ResultSrcE;
      ALUResultM <= ex_result;
      WriteDataM <= src_b_fwd;
      PCPlus4M   <= PCPlus4E;
    end
  end

endmodule

// File: tb/tb_execute_cycle.sv
// tb/tb_execute_cycle.sv - randomized self-checking bench for execute_cycle against a behavioural model
module tb_execute_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE;
  logic [2:0]  ALUControlE;
  logic        MulDivE;
  logic [2:0]  MulDivOpE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic [31:0] ResultW;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        StallE;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_alu_m;

`ifdef EXEC_MULDIV_EN
  localparam bit MD_BUILD = 1'b1;
`else
  localparam bit MD_BUILD = 1'b0;
`endif

  always #5 clk = ~clk;

  execute_cycle dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .MulDivE(MulDivE), .MulDivOpE(MulDivOpE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .RD_E(RD_E), .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .ResultW(ResultW),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallE(StallE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rf,
                                      input logic [31:0] wb, input logic [31:0] mem);
    if (sel == 2'b01) return wb;
    if (sel == 2'b10) return mem;
    return rf;
  endfunction

  function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (op == 3'd0) return a + b;
    if (op == 3'd1) return a - b;
    if (op == 3'd2) return a & b;
    if (op == 3'd3) return a | b;
    if (op == 3'd5) return (sa < sb) ? 32'd1 : 32'd0;
    return 32'd0;
  endfunction

  task automatic rand_inputs(input bit allow_md);
    RegWriteE   = 1'($urandom);
    MemWriteE   = 1'($urandom);
    ResultSrcE  = 1'($urandom);
    BranchE     = 1'($urandom);
    ALUSrcE     = 1'($urandom);
    ALUControlE = 3'($urandom);
    MulDivE     = allow_md ? 1'($urandom) : 1'b0;
    MulDivOpE   = 3'($urandom);
    RD1_E       = $urandom;
    RD2_E       = ($urandom_range(0, 3) == 0) ? RD1_E : $urandom;
    Imm_Ext_E   = $urandom;
    PCE         = $urandom;
    PCPlus4E    = PCE + 32'd4;
    RD_E        = 5'($urandom);
    ForwardA_E  = 2'($urandom);
    ForwardB_E  = 2'($urandom);
    ResultW     = $urandom;
  endtask

  task automatic run_alu(input string tag);
    logic [31:0] a, bf, b, res;
    a   = fwd(ForwardA_E, RD1_E, ResultW, model_alu_m);
    bf  = fwd(ForwardB_E, RD2_E, ResultW, model_alu_m);
    b   = ALUSrcE ? Imm_Ext_E : bf;
    res = alu_model(ALUControlE, a, b);
    #1;
    check({tag, ".pcsrc"}, 32'(PCSrcE), 32'(BranchE && (res == 32'd0)));
    check({tag, ".pctarget"}, PCTargetE, PCE + Imm_Ext_E);
    check({tag, ".stall"}, 32'(StallE), 32'd0);
    tick();
    check({tag, ".alu_m"}, ALUResultM, res);
    check({tag, ".wd_m"}, WriteDataM, bf);
    check({tag, ".rw_m"}, 32'(RegWriteM), 32'(RegWriteE));
    check({tag, ".mw_m"}, 32'(MemWriteM), 32'(MemWriteE));
    check({tag, ".rs_m"}, 32'(ResultSrcM), 32'(ResultSrcE));
    check({tag, ".rd_m"}, 32'(RD_M), 32'(RD_E));
    check({tag, ".pc4_m"}, PCPlus4M, PCPlus4E);
    model_alu_m = res;
  endtask

`ifdef EXEC_MULDIV_EN
  function automatic logic [31:0] md_model(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  task automatic run_md(input string tag, input logic [2:0] op);
    logic [31:0] a, b, res, exp_wd;
    int stalls;
    MulDivE   = 1'b1;
    MulDivOpE = op;
    BranchE   = 1'b0;
    a   = fwd(ForwardA_E, RD1_E, ResultW, model_alu_m);
    b   = fwd(ForwardB_E, RD2_E, ResultW, model_alu_m);
    res = md_model(op, a, b);
    #1;
    stalls = 0;
    while (StallE === 1'b1 && stalls < 40) begin
      stalls++;
      tick();
      check({tag, ".bubble_rw"}, 32'(RegWriteM), 32'd0);
      check({tag, ".bubble_mw"}, 32'(MemWriteM), 32'd0);
      check({tag, ".bubble_rd"}, 32'(RD_M), 32'd0);
      ResultW = $urandom;
      #1;
    end
    check({tag, ".stall_cycles"}, stalls, 32'd33);
    exp_wd = fwd(ForwardB_E, RD2_E, ResultW, model_alu_m);
    tick();
    check({tag, ".result"}, ALUResultM, res);
    check({tag, ".rw_m"}, 32'(RegWriteM), 32'(RegWriteE));
    check({tag, ".mw_m"}, 32'(MemWriteM), 32'(MemWriteE));
    check({tag, ".rs_m"}, 32'(ResultSrcM), 32'(ResultSrcE));
    check({tag, ".rd_m"}, 32'(RD_M), 32'(RD_E));
    check({tag, ".pc4_m"}, PCPlus4M, PCPlus4E);
    if (ForwardB_E != 2'b10) check({tag, ".wd_m"}, WriteDataM, exp_wd);
    model_alu_m = res;
    MulDivE = 1'b0;
  endtask

  task automatic plain_md_inputs(input logic [31:0] a, input logic [31:0] b);
    rand_inputs(1'b0);
    RegWriteE  = 1'b1;
    ForwardA_E = 2'b00;
    ForwardB_E = 2'b00;
    RD1_E      = a;
    RD2_E      = b;
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rand_inputs(1'b0);
    rst = 1'b1;
    repeat (2) tick();
    check("reset.rw_m", 32'(RegWriteM), 32'd0);
    check("reset.mw_m", 32'(MemWriteM), 32'd0);
    check("reset.rs_m", 32'(ResultSrcM), 32'd0);
    check("reset.rd_m", 32'(RD_M), 32'd0);
    check("reset.alu_m", ALUResultM, 32'd0);
    check("reset.wd_m", WriteDataM, 32'd0);
    check("reset.pc4_m", PCPlus4M, 32'd0);
    check("reset.stall", 32'(StallE), 32'd0);
    rst = 1'b0;
    model_alu_m = 32'd0;

    // forwarding chain: 2+3=5, then MEM-forwarded 5+7=12, then 12-WB(3)=9
    rand_inputs(1'b0);
    BranchE = 1'b0; ALUSrcE = 1'b0; ALUControlE = 3'd0;
    ForwardA_E = 2'b00; ForwardB_E = 2'b00; RD1_E = 32'd2; RD2_E = 32'd3;
    run_alu("add_base");
    ForwardA_E = 2'b10; RD1_E = 32'hDEAD_BEEF; RD2_E = 32'd7;
    run_alu("fwd_mem");
    check("fwd_mem.const", ALUResultM, 32'd12);
    ALUControlE = 3'd1; ForwardB_E = 2'b01; ResultW = 32'd3;
    run_alu("fwd_wb");
    check("fwd_wb.const", ALUResultM, 32'd9);

    BranchE = 1'b1; ALUSrcE = 1'b0; ALUControlE = 3'd1;
    ForwardA_E = 2'b00; ForwardB_E = 2'b00;
    RD1_E = 32'h1234; RD2_E = 32'h1234; PCE = 32'h100; Imm_Ext_E = 32'h20;
    #1;
    check("beq_taken.pcsrc", 32'(PCSrcE), 32'd1);
    check("beq_taken.target", PCTargetE, 32'h120);
    run_alu("beq_taken");
    RD2_E = 32'h1235;
    #1;
    check("beq_not.pcsrc", 32'(PCSrcE), 32'd0);
    run_alu("beq_not");
    PCE = 32'hFFFF_FFF0; Imm_Ext_E = 32'h20;
    #1;
    check("target_wrap", PCTargetE, 32'h10);
    BranchE = 1'b0; ALUControlE = 3'd5; RD1_E = 32'h8000_0000; RD2_E = 32'd1;
    run_alu("slt_signed");
    check("slt_signed.const", ALUResultM, 32'd1);

    for (int i = 0; i < 300; i++) begin
      rand_inputs(!MD_BUILD);
      run_alu("rand_alu");
    end

`ifdef EXEC_MULDIV_EN
    plain_md_inputs(32'h1234_5678, 32'h9);
    MulDivE = 1'b1; MulDivOpE = 3'd0; BranchE = 1'b0;
    repeat (11) tick();
    rst = 1'b1; MulDivE = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    model_alu_m = 32'd0;
    check("rst_busy.stall", 32'(StallE), 32'd0);
    check("rst_busy.rw_m", 32'(RegWriteM), 32'd0);
    check("rst_busy.mw_m", 32'(MemWriteM), 32'd0);
    check("rst_busy.rd_m", 32'(RD_M), 32'd0);
    check("rst_busy.alu_m", ALUResultM, 32'd0);
    check("rst_busy.pc4_m", PCPlus4M, 32'd0);

    plain_md_inputs(32'hFFFF_FFFF, 32'h2);
    run_md("mulh", 3'd1);
    check("mulh.const", ALUResultM, 32'hFFFF_FFFF);
    check("mulh.rw", 32'(RegWriteM), 32'd1);
    plain_md_inputs(32'd7, 32'd0);
    run_md("divu_zero", 3'd5);
    check("divu_zero.const", ALUResultM, 32'hFFFF_FFFF);
    plain_md_inputs(32'd7, 32'd0);
    run_md("rem_zero", 3'd6);
    check("rem_zero.const", ALUResultM, 32'd7);
    plain_md_inputs(32'h8000_0000, 32'hFFFF_FFFF);
    run_md("div_ovf", 3'd4);
    check("div_ovf.const", ALUResultM, 32'h8000_0000);
    plain_md_inputs(32'hFFFF_FFF9, 32'd0);
    run_md("div_neg_zero", 3'd4);
    check("div_neg_zero.const", ALUResultM, 32'hFFFF_FFFF);

    for (int i = 0; i < 40; i++) begin
      rand_inputs(1'b0);
      if ($urandom_range(0, 4) == 0) RD2_E = 32'd0;
      run_md("rand_md", 3'($urandom));
      if ($urandom_range(0, 1) == 0) begin
        rand_inputs(1'b0);
        ForwardA_E = 2'b10;
        run_alu("after_md");
      end
    end
`else
    rand_inputs(1'b1);
    MulDivE = 1'b1; BranchE = 1'b0; ALUSrcE = 1'b0; ALUControlE = 3'd0;
    ForwardA_E = 2'b00; ForwardB_E = 2'b00; RD1_E = 32'd2; RD2_E = 32'd3;
    run_alu("md_off");
    check("md_off.const", ALUResultM, 32'd5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
